bnn_mul_acc_pipe: RTL and testbench
===================================

Name: bnn_mul_acc_pipe

Overview:
- Parametrised successor to the fixed-format HLS multiplier cores (e.g. the 32s x 11ns, 2-stage multiplier).
- Multiplies two operands whose signedness is selected at run time.
- Pipelines the result through a configurable number of stages, tracks valid beats, and optionally accumulates into a wide register.
- Output is saturated or truncated to DOUT_WIDTH. Used in the BNN datapath for threshold and scale accumulation.

Parameters:
- DIN0_WIDTH, 32, width of operand din0.
- DIN1_WIDTH, 11, width of operand din1.
- DOUT_WIDTH, 32, width of dout.
- NUM_STAGE, 2, pipeline latency in enabled cycles. Legal range is 1 to 8.
- ACC_WIDTH, 48, accumulator width. Must be at least DIN0_WIDTH+DIN1_WIDTH+2 and at least DOUT_WIDTH.
- SAT, 1, output format. 1 means signed saturation to DOUT_WIDTH; 0 means truncation to the low DOUT_WIDTH bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable. 0 freezes every register.
- in_valid  in  1  din0/din1/mode/acc controls carry a beat this cycle.
- din0  in  DIN0_WIDTH  operand 0.
- din1  in  DIN1_WIDTH  operand 1.
- din0_signed  in  1  1 means din0 is two's complement; 0 means unsigned.
- din1_signed  in  1  same as din0_signed, for din1.
- acc_en  in  1  1 adds the product to the accumulator; 0 loads the product.
- acc_clr  in  1  with acc_en=1, the product is added to 0 (starts a new sum).
- out_valid  out  1  dout holds the result of a new beat.
- dout  out  DOUT_WIDTH  accumulator formatted per SAT.
- overflow  out  1  the accumulator value is not representable in DOUT_WIDTH signed.

Behaviour:
- Reset and clock enable:
  - Synchronous active-high reset on clk. Reset has priority over ce.
  - Reset clears all stage valid bits, the accumulator, out_valid and overflow, so dout=0.
  - ce=0: no register changes, including valids and the accumulator. out_valid and dout hold their values.
- Operand extension at the input stage:
  - din0 is extended to DIN0_WIDTH+1 bits signed, sign-extended or zero-extended per din0_signed.
  - din1 is extended the same way to DIN1_WIDTH+1 bits per din1_signed.
  - Full-precision product width is P = DIN0_WIDTH+DIN1_WIDTH+2. The product is exact and never wraps.
- Pipeline structure and latency:
  - NUM_STAGE register stages. Each stage carries the data plus valid, acc_en and acc_clr.
  - The final stage is the accumulator register.
  - A beat accepted when ce=1 and in_valid=1 appears with out_valid=1 after exactly NUM_STAGE ce=1 cycles.
  - With NUM_STAGE=1, the multiply and the accumulate update happen in one register.
  - Throughput is one beat per enabled cycle. There is no backpressure.
- Final-stage update, with s the product sign-extended to ACC_WIDTH:
  - acc_en=0: acc <= s.
  - acc_en=1 and acc_clr=1: acc <= s.
  - acc_en=1 and acc_clr=0: acc <= acc + s, modulo 2^ACC_WIDTH (wraps silently).
  - Non-valid beats leave acc unchanged and drive out_valid=0.
- Output formatting (combinational from the acc register, adds no latency):
  - SAT=1: dout = acc clamped to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
  - SAT=0: dout = acc[DOUT_WIDTH-1:0].
  - overflow=1 whenever acc is outside the signed DOUT_WIDTH range, in either SAT mode.
- Reset mid-operation: in-flight beats are discarded. No stale out_valid appears after reset.
- Modes may change every beat. Each beat's modes travel with that beat.

Test Plan:
1. Defaults; din0=-5, din0_signed=1, din1=2047, din1_signed=0, acc_en=0 -> 2 cycles later out_valid=1, dout=-10235, overflow=0.
2. Signed din1: din1=11'h7FF, din1_signed=1, din0=100 signed -> dout=-100. Same inputs with din1_signed=0 -> dout=204700.
3. Back-to-back beats (3,4) with acc_en=1, acc_clr=1, then (5,6) and (-2,7) with acc_en=1, acc_clr=0 -> dout sequence 12, 42, 28 on consecutive cycles. A following acc_clr beat (1,1) -> dout=1.
4. Saturation:
   - din0=0x7FFFFFFF signed, din1=2047 unsigned -> dout=0x7FFFFFFF, overflow=1.
   - din0=0x80000000 signed -> dout=0x80000000, overflow=1.
   - SAT=0 build with the first input -> dout=acc[31:0]=0x7FFFF801, overflow=1.
5. Clock enable stall: ce held low 3 cycles with 2 beats in flight -> out_valid/dout frozen, no beat lost or duplicated, latency stretched by 3. Reset with 2 beats in flight -> next cycle out_valid=0, dout=0, no beat emerges later.
6. Parameter sweep NUM_STAGE=1, 4, 8 with random signed/unsigned stimulus against a scoreboard -> latency equals NUM_STAGE, results bit-exact, accumulator wraps modulo 2^ACC_WIDTH.

Source files
------------

// File: rtl/bnn_mul_acc_pipe_if.sv
// rtl/bnn_mul_acc_pipe_if.sv - operand beat and formatted result bundle for bnn_mul_acc_pipe
interface bnn_mul_acc_pipe_if #(
    parameter int DIN0_WIDTH = 32,
    parameter int DIN1_WIDTH = 11,
    parameter int DOUT_WIDTH = 32
);
    logic                  in_valid;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  din0_signed;
    logic                  din1_signed;
    logic                  acc_en;
    logic                  acc_clr;
    logic                  out_valid;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  overflow;

    modport master (
        output in_valid, din0, din1, din0_signed, din1_signed, acc_en, acc_clr,
        input  out_valid, dout, overflow
    );

    modport slave (
        input  in_valid, din0, din1, din0_signed, din1_signed, acc_en, acc_clr,
        output out_valid, dout, overflow
    );
endinterface

// File: rtl/bnn_mul_acc_pipe.sv
// rtl/bnn_mul_acc_pipe.sv - run-time signed/unsigned multiplier with pipelined accumulate and saturating output
module bnn_mul_acc_pipe #(
    parameter int DIN0_WIDTH = 32,
    parameter int DIN1_WIDTH = 11,
    parameter int DOUT_WIDTH = 32,
    parameter int NUM_STAGE  = 2,
    parameter int ACC_WIDTH  = 48,
    parameter int SAT        = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    bnn_mul_acc_pipe_if.slave bus
);
    localparam int P = DIN0_WIDTH + DIN1_WIDTH + 2;
    localparam logic [DOUT_WIDTH-1:0] DOUT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic [DOUT_WIDTH-1:0] DOUT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

    // One extra bit per operand lets both signednesses share a signed multiplier.
    logic signed [P-1:0] op0_ext;
    logic signed [P-1:0] op1_ext;
    logic signed [P-1:0] prod;

    always_comb begin
        op0_ext = P'($signed({bus.din0_signed & bus.din0[DIN0_WIDTH-1], bus.din0}));
        op1_ext = P'($signed({bus.din1_signed & bus.din1[DIN1_WIDTH-1], bus.din1}));
        prod    = op0_ext * op1_ext;
    end

    logic signed [P-1:0] fin_prod;
    logic                fin_valid;
    logic                fin_acc_en;
    logic                fin_acc_clr;

    if (NUM_STAGE > 1) begin : g_pipe
        localparam int D = NUM_STAGE - 1;
        logic signed [P-1:0] prod_q [D];
        logic [D-1:0]        valid_q;
        logic [D-1:0]        acc_en_q;
        logic [D-1:0]        acc_clr_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= '0;
            end else if (ce) begin
                prod_q[0]    <= prod;
                valid_q[0]   <= bus.in_valid;
                acc_en_q[0]  <= bus.acc_en;
                acc_clr_q[0] <= bus.acc_clr;
                for (int i = 1; i < D; i++) begin
                    prod_q[i]    <= prod_q[i-1];
                    valid_q[i]   <= valid_q[i-1];
                    acc_en_q[i]  <= acc_en_q[i-1];
                    acc_clr_q[i] <= acc_clr_q[i-1];
                end
            end
        end

        assign fin_prod    = prod_q[D-1];
        assign fin_valid   = valid_q[D-1];
        assign fin_acc_en  = acc_en_q[D-1];
        assign fin_acc_clr = acc_clr_q[D-1];
    end else begin : g_direct
        assign fin_prod    = prod;
        assign fin_valid   = bus.in_valid;
        assign fin_acc_en  = bus.acc_en;
        assign fin_acc_clr = bus.acc_clr;
    end

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] prod_acc;
    logic                        out_valid_q;
    logic                        out_valid_d;

    assign prod_acc = ACC_WIDTH'(fin_prod);

    always_comb begin
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        if (fin_valid) begin
            out_valid_d = 1'b1;
            if (fin_acc_en && !fin_acc_clr) begin
                acc_d = acc_q + prod_acc;
            end else begin
                acc_d = prod_acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (ce) begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Representable in DOUT_WIDTH signed iff every bit above the DOUT sign bit equals it.
    logic [ACC_WIDTH-DOUT_WIDTH:0] acc_top;
    logic                          acc_fits;
    logic [DOUT_WIDTH-1:0]         dout_fmt;

    assign acc_top  = acc_q[ACC_WIDTH-1:DOUT_WIDTH-1];
    assign acc_fits = (&acc_top) | ~(|acc_top);

    always_comb begin
        dout_fmt = acc_q[DOUT_WIDTH-1:0];
        if (SAT != 0 && !acc_fits) begin
            dout_fmt = acc_q[ACC_WIDTH-1] ? DOUT_MIN : DOUT_MAX;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_fmt;
    assign bus.overflow  = ~acc_fits;
endmodule

// File: tb/tb_bnn_mul_acc_pipe.sv
// tb/tb_bnn_mul_acc_pipe.sv - scoreboard bench over five builds of bnn_mul_acc_pipe
module tb_bnn_mul_acc_pipe;
    localparam int NI = 5;
    localparam logic [4:0][3:0] NS_T  = {4'd8, 4'd4, 4'd1, 4'd2, 4'd2};
    localparam logic [4:0]      SAT_T = 5'b01101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] din0 = '0;
    logic [10:0] din1 = '0;
    logic        din0_signed = 1'b0;
    logic        din1_signed = 1'b0;
    logic        acc_en = 1'b0;
    logic        acc_clr = 1'b0;

    logic        obs_valid [NI];
    logic [31:0] obs_dout  [NI];
    logic        obs_ovf   [NI];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bnn_mul_acc_pipe_if #(.DIN0_WIDTH(32), .DIN1_WIDTH(11), .DOUT_WIDTH(32)) bus ();

        assign bus.in_valid    = in_valid;
        assign bus.din0        = din0;
        assign bus.din1        = din1;
        assign bus.din0_signed = din0_signed;
        assign bus.din1_signed = din1_signed;
        assign bus.acc_en      = acc_en;
        assign bus.acc_clr     = acc_clr;
        assign obs_valid[g]    = bus.out_valid;
        assign obs_dout[g]     = bus.dout;
        assign obs_ovf[g]      = bus.overflow;

        bnn_mul_acc_pipe #(
            .DIN0_WIDTH(32), .DIN1_WIDTH(11), .DOUT_WIDTH(32),
            .NUM_STAGE(int'(NS_T[g])), .ACC_WIDTH(48), .SAT(int'(SAT_T[g]))
        ) u_dut (
            .clk  (clk),
            .reset(reset),
            .ce   (ce),
            .bus  (bus)
        );
    end

    typedef struct {
        logic [31:0] dout;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t        sbq  [NI][$];
    logic [47:0] macc [NI];
    int          en_cnt  = 0;
    bit          last_en = 1'b0;

    function automatic logic [47:0] prod_of(logic [31:0] a, logic [10:0] b, logic sa, logic sb);
        logic signed [47:0] ea;
        logic signed [47:0] eb;
        ea = sa ? 48'(signed'(a)) : {16'd0, a};
        eb = sb ? 48'(signed'(b)) : {37'd0, b};
        return ea * eb;
    endfunction

    function automatic logic [32:0] fmt(logic [47:0] acc, logic sat);
        logic signed [47:0] s;
        logic               ovf;
        logic [31:0]        d;
        s   = acc;
        ovf = (s > 48'sd2147483647) || (s < -48'sd2147483648);
        d   = acc[31:0];
        if (sat && s > 48'sd2147483647) d = 32'h7FFF_FFFF;
        if (sat && s < -48'sd2147483648) d = 32'h8000_0000;
        return {ovf, d};
    endfunction

    // Reference: every accepted beat updates a per-build accumulator in order.
    initial begin
        logic [47:0] p;
        logic [32:0] f;
        exp_t        e;
        forever begin
            @(posedge clk);
            if (reset) begin
                last_en = 1'b0;
                for (int i = 0; i < NI; i++) begin
                    sbq[i].delete();
                    macc[i] = '0;
                end
            end else if (ce) begin
                en_cnt++;
                last_en = 1'b1;
                if (in_valid) begin
                    p = prod_of(din0, din1, din0_signed, din1_signed);
                    for (int i = 0; i < NI; i++) begin
                        if (acc_en && !acc_clr) macc[i] = macc[i] + p;
                        else macc[i] = p;
                        f = fmt(macc[i], SAT_T[i]);
                        e.dout = f[31:0];
                        e.ovf  = f[32];
                        e.due  = en_cnt + int'(NS_T[i]) - 1;
                        sbq[i].push_back(e);
                    end
                end
            end else begin
                last_en = 1'b0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (last_en) begin
                for (int i = 0; i < NI; i++) begin
                    if (obs_valid[i]) begin
                        n_tests++;
                        if (sbq[i].size() == 0) begin
                            n_fail++;
                            $display("FAIL sb_unexpected[%0d] got dout=%h at cycle %0d, expected no beat", i, obs_dout[i], en_cnt);
                        end else begin
                            e = sbq[i].pop_front();
                            if (obs_dout[i] !== e.dout || obs_ovf[i] !== e.ovf || en_cnt != e.due) begin
                                n_fail++;
                                $display("FAIL sb_beat[%0d] got dout=%h ovf=%b cycle=%0d, expected dout=%h ovf=%b cycle=%0d",
                                         i, obs_dout[i], obs_ovf[i], en_cnt, e.dout, e.ovf, e.due);
                            end
                        end
                    end else if (sbq[i].size() > 0 && sbq[i][0].due <= en_cnt) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_missing[%0d] got out_valid=0 at cycle %0d, expected beat dout=%h", i, en_cnt, sbq[i][0].dout);
                        void'(sbq[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion, expected finish before timeout");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [31:0] a, input logic [10:0] b, input logic sa, input logic sb,
                         input logic ae, input logic ac);
        in_valid    = 1'b1;
        din0        = a;
        din1        = b;
        din0_signed = sa;
        din1_signed = sb;
        acc_en      = ae;
        acc_clr     = ac;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_tests++;
            if (obs_valid[i] !== 1'b0 || obs_dout[i] !== 32'd0 || obs_ovf[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state[%0d] got v=%b d=%h o=%b, expected 0/0/0", i, obs_valid[i], obs_dout[i], obs_ovf[i]);
            end
        end
    endtask

    task automatic test_default;
        drive(32'hFFFF_FFFB, 11'd2047, 1'b1, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL default_early got out_valid=%b, expected 0", obs_valid[0]);
        end
        idle(1);
        @(negedge clk);
        n_tests++;
        if (obs_valid[0] !== 1'b1 || obs_dout[0] !== 32'hFFFF_D805 || obs_ovf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL default_beat got v=%b d=%h o=%b, expected 1/ffffd805/0", obs_valid[0], obs_dout[0], obs_ovf[0]);
        end
        idle(8);
    endtask

    task automatic test_signedness;
        drive(32'd100, 11'h7FF, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(32'd100, 11'h7FF, 1'b1, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs_dout[0] !== 32'hFFFF_FF9C) begin
            n_fail++;
            $display("FAIL signed_din1 got %h, expected ffffff9c", obs_dout[0]);
        end
        idle(1);
        @(negedge clk);
        n_tests++;
        if (obs_dout[0] !== 32'd204700) begin
            n_fail++;
            $display("FAIL unsigned_din1 got %0d, expected 204700", obs_dout[0]);
        end
        idle(8);
    endtask

    task automatic test_back_to_back;
        logic [31:0] a  [4] = '{32'd3, 32'd5, 32'hFFFF_FFFE, 32'd1};
        logic [10:0] b  [4] = '{11'd4, 11'd6, 11'd7, 11'd1};
        logic        ac [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ex [4] = '{32'd12, 32'd42, 32'd28, 32'd1};
        drive(a[0], b[0], 1'b1, 1'b1, 1'b1, ac[0]);
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) drive(a[k], b[k], 1'b1, 1'b1, 1'b1, ac[k]);
            else idle(1);
            @(negedge clk);
            n_tests++;
            if (obs_valid[0] !== 1'b1 || obs_dout[0] !== ex[k-1]) begin
                n_fail++;
                $display("FAIL acc_seq%0d got v=%b d=%0d, expected 1/%0d", k, obs_valid[0], obs_dout[0], ex[k-1]);
            end
        end
        idle(8);
    endtask

    task automatic test_saturation;
        drive(32'h7FFF_FFFF, 11'd2047, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(32'h8000_0000, 11'd2047, 1'b1, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs_dout[0] !== 32'h7FFF_FFFF || obs_ovf[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pos got d=%h o=%b, expected 7fffffff/1", obs_dout[0], obs_ovf[0]);
        end
        n_tests++;
        if (obs_dout[1] !== 32'h7FFF_F801 || obs_ovf[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL trunc_pos got d=%h o=%b, expected 7ffff801/1", obs_dout[1], obs_ovf[1]);
        end
        idle(1);
        @(negedge clk);
        n_tests++;
        if (obs_dout[0] !== 32'h8000_0000 || obs_ovf[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_neg got d=%h o=%b, expected 80000000/1", obs_dout[0], obs_ovf[0]);
        end
        idle(8);
    endtask

    task automatic test_stall_and_reset;
        drive(32'd7, 11'h7FD, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(32'hFFFF_FFFA, 11'h7FA, 1'b1, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (obs_valid[0] !== 1'b1 || obs_dout[0] !== 32'hFFFF_FFEB) begin
                n_fail++;
                $display("FAIL stall_hold%0d got v=%b d=%h, expected 1/ffffffeb", k, obs_valid[0], obs_dout[0]);
            end
        end
        ce = 1'b1;
        @(negedge clk);
        n_tests++;
        if (obs_valid[0] !== 1'b1 || obs_dout[0] !== 32'd36) begin
            n_fail++;
            $display("FAIL stall_resume got v=%b d=%0d, expected 1/36", obs_valid[0], obs_dout[0]);
        end
        @(negedge clk);
        n_tests++;
        if (obs_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_dup got out_valid=%b, expected 0", obs_valid[0]);
        end
        idle(10);

        drive(32'd9, 11'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(32'd9, 11'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_tests++;
            if (obs_valid[i] !== 1'b0 || obs_dout[i] !== 32'd0 || obs_ovf[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset[%0d] got v=%b d=%h o=%b, expected 0/0/0", i, obs_valid[i], obs_dout[i], obs_ovf[i]);
            end
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                n_tests++;
                if (obs_valid[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stale_beat[%0d] got out_valid=1 cycle %0d after reset, expected 0", i, k);
                end
            end
        end
    endtask

    task automatic test_sweep;
        for (int k = 0; k < 300; k++) begin
            ce          = ($urandom_range(0, 7) != 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            din0        = $urandom;
            din1        = 11'($urandom);
            din0_signed = 1'($urandom);
            din1_signed = 1'($urandom);
            acc_en      = 1'($urandom);
            acc_clr     = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            #1;
        end
        ce = 1'b1;
        drive(32'hFFFF_FFFF, 11'h7FF, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 64; k++) begin
            drive(32'hFFFF_FFFF, 11'h7FF, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        idle(12);
        for (int i = 0; i < NI; i++) begin
            n_tests++;
            if (sbq[i].size() != 0) begin
                n_fail++;
                $display("FAIL drain[%0d] got %0d beats outstanding, expected 0", i, sbq[i].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_signedness();
        test_back_to_back();
        test_saturation();
        test_stall_and_reset();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
